// File: rtl/iir_pkg.sv
// Shared constants for the IIR output path: Q4.12 format, saturation limits, default widths.
// Latency: none (constants only).
// Backpressure: not applicable.
package iir_pkg;

  // Q4.12 output format
  localparam int          FRAC_BITS = 12;
  localparam logic [15:0] Q_ONE     = 16'h1000;

  // Saturation limits of the 16-bit signed output
  localparam logic [15:0] SAT_MAX   = 16'h7FFF;
  localparam logic [15:0] SAT_MIN   = 16'h8000;

  // Default widths and depths
  localparam int DEF_DATA_IN_W  = 32;
  localparam int DEF_DATA_OUT_W = 16;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/iir_sync_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and an occupancy count.
// Latency: a pushed word is readable at the head on the cycle after the push edge.
// Backpressure: push while full is ignored unless a pop happens on the same edge; pop while empty is ignored.
module iir_sync_fifo
  import iir_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_OUT_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH[AW:0]);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so the output is clean after reset.
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy update; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/iir_output_formatter.sv
// Requantizes 32-bit IIR accumulator samples to Q4.12 (round-half-up, saturate), buffers and counts events.
// Latency: in_valid at edge E gives out_valid during the cycle after edge E+1 (two edges), one sample per cycle.
// Backpressure: none on input; a full FIFO with no pop drops the sample and bumps drop_count.
module iir_output_formatter
  import iir_pkg::*;
#(
  parameter int DATA_IN_W  = DEF_DATA_IN_W,
  parameter int DATA_OUT_W = DEF_DATA_OUT_W,
  parameter int FRAC_SHIFT = FRAC_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [DATA_IN_W-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DATA_OUT_W-1:0]  out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          sat_flag,
  output logic [CNT_W-1:0]              sat_count,
  output logic [CNT_W-1:0]              drop_count,
  input  logic                          clr_stats
);

  // Rounding offset of one half LSB of the output, at the widened sum width.
  localparam logic signed [DATA_IN_W:0] RND =
    {{DATA_IN_W{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  localparam logic [DATA_OUT_W-1:0] SAT_P = {1'b0, {(DATA_OUT_W-1){1'b1}}};
  localparam logic [DATA_OUT_W-1:0] SAT_N = {1'b1, {(DATA_OUT_W-1){1'b0}}};

  logic signed [DATA_IN_W:0]          rq_sum;
  logic signed [DATA_IN_W:0]          rq_shift;
  logic [DATA_IN_W-DATA_OUT_W+1:0]    rq_upper;
  logic                               rq_sat_hi;
  logic                               rq_sat_lo;
  logic [DATA_OUT_W-1:0]              rq_res;

  logic                               stage_vld;
  logic [DATA_OUT_W-1:0]              stage_dat;

  logic                               fifo_full;
  logic                               fifo_empty;
  logic                               fifo_pop;
  logic [DATA_OUT_W-1:0]              fifo_head;

  logic                               sat_evt;
  logic                               drop_evt;

  // Requantize: widen by one bit so the rounding add cannot wrap, shift, then clamp.
  always_comb begin
    rq_sum    = {in_data[DATA_IN_W-1], in_data} + RND;
    rq_shift  = rq_sum >>> FRAC_SHIFT;
    // The value fits when every bit from the output sign bit upward agrees.
    rq_upper  = rq_shift[DATA_IN_W:DATA_OUT_W-1];
    rq_sat_hi = !rq_shift[DATA_IN_W] && (|rq_upper);
    rq_sat_lo =  rq_shift[DATA_IN_W] && !(&rq_upper);
    if (rq_sat_hi)      rq_res = SAT_P;
    else if (rq_sat_lo) rq_res = SAT_N;
    else                rq_res = rq_shift[DATA_OUT_W-1:0];
  end

  // Stage register: valid tracks in_valid every cycle, data only loads on a sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_vld <= 1'b0;
      stage_dat <= '0;
    end else begin
      stage_vld <= in_valid;
      if (in_valid) stage_dat <= rq_res;
    end
  end

  assign fifo_pop  = out_valid && out_ready;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head;

  iir_sync_fifo #(
    .WIDTH (DATA_OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (stage_vld),
    .push_dat (stage_dat),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Saturation is counted when the sample enters the stage, so a later drop counts separately.
  assign sat_evt  = in_valid && (rq_sat_hi || rq_sat_lo);
  assign drop_evt = stage_vld && fifo_full && !fifo_pop;

  // Statistics: clear has priority over any event on the same edge; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_flag   <= 1'b0;
      sat_count  <= '0;
      drop_count <= '0;
    end else if (clr_stats) begin
      sat_flag   <= 1'b0;
      sat_count  <= '0;
      drop_count <= '0;
    end else begin
      if (sat_evt) begin
        sat_flag <= 1'b1;
        if (sat_count != '1) sat_count <= sat_count + 1'b1;
      end
      if (drop_evt && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

endmodule
